mmio_csr_bank: RTL

MMIO_CSR_BANK -- requirements
Module: mmio_csr_bank

---
 rtl/mmio_csr_pkg.sv | 70 +++++++
 rtl/mmio_csr_bank_if.sv | 11 +
 rtl/mmio_rd_pipe.sv | 47 ++++
 rtl/mmio_csr_bank.sv | 110 +++++++++++
 4 files changed

// File: rtl/mmio_csr_pkg.sv
// Shared CCI-P MMIO types and CSR bank constants.
package mmio_csr_pkg;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 4;
    localparam int NUM_REGS_MIN = 2;
    localparam int NUM_REGS_MAX = 1024;

    typedef logic [1:0] t_mmio_len;
    localparam t_mmio_len MMIO_LEN_4B = 2'd0;
    localparam t_mmio_len MMIO_LEN_8B = 2'd1;

    typedef logic [8:0]  t_ccip_tid;
    typedef logic [15:0] t_ccip_mmioAddr;

    typedef struct packed {
        t_ccip_mmioAddr address;
        t_mmio_len      length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [63:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [63:0] hdr;
        logic [63:0] data;
        logic        valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // Bits of a 64-bit register touched by an access of the given size/half.
    function automatic logic [63:0] lane_mask(input logic is_8b, input logic upper);
        if (is_8b)
            return '1;
        return upper ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
    endfunction

endpackage

// File: rtl/mmio_csr_bank_if.sv
// Read request/response bundle between the CSR decode and the response delay line.
interface mmio_csr_bank_if;
    import mmio_csr_pkg::*;

    logic        rd_vld;
    t_ccip_tid   rd_tid;
    logic [63:0] rd_dat;

    modport master (output rd_vld, rd_tid, rd_dat);
    modport slave  (input  rd_vld, rd_tid, rd_dat);
endinterface

// File: rtl/mmio_rd_pipe.sv
// Purpose: fixed-length delay line for MMIO read responses (valid, tid, data).
// Latency: exactly RD_LATENCY cycles from req to rsp.
// Backpressure: none; accepts one request per cycle, order preserved.
module mmio_rd_pipe
    import mmio_csr_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mmio_csr_bank_if.slave   req,
    mmio_csr_bank_if.master  rsp
);

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
        $error("mmio_rd_pipe: RD_LATENCY must be within 1..4");
    end

    logic [RD_LATENCY-1:0] vld_q;
    t_ccip_tid             tid_q [RD_LATENCY];
    logic [63:0]           dat_q [RD_LATENCY];

    // Reset flushes everything in flight so no stale response follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tid_q[s] <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= req.rd_vld;
            tid_q[0] <= req.rd_tid;
            dat_q[0] <= req.rd_dat;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                tid_q[s] <= tid_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign rsp.rd_vld = vld_q[RD_LATENCY-1];
    assign rsp.rd_tid = tid_q[RD_LATENCY-1];
    assign rsp.rd_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/mmio_csr_bank.sv
// Purpose: bank of 64-bit CSRs, host-accessible over CCI-P MMIO, AFU-updatable on ~WR_MASK bits.
// Latency: reads answered on c2 exactly RD_LATENCY cycles after the request; writes land next edge.
// Backpressure: none; one MMIO request per cycle, every read gets a response.
module mmio_csr_bank
    import mmio_csr_pkg::*;
#(
    parameter int                          NUM_REGS   = 16,
    parameter int                          RD_LATENCY = 2,
    parameter logic [NUM_REGS-1:0][63:0]   REG_INIT   = '0,
    parameter logic [NUM_REGS-1:0][63:0]   WR_MASK    = '1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  t_if_ccip_Rx                   cp2af_sRxPort,
    output t_if_ccip_Tx                   af2cp_sTxPort,
    input  logic                          hw_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]   hw_wr_idx,
    input  logic [63:0]                   hw_wr_data,
    output logic [NUM_REGS*64-1:0]        csr_q,
    output logic [15:0]                   err_cnt
);

    localparam int IDX_W = $clog2(NUM_REGS);

    if (NUM_REGS < NUM_REGS_MIN || NUM_REGS > NUM_REGS_MAX) begin : g_bad_regs
        $error("mmio_csr_bank: NUM_REGS must be within 2..1024");
    end

    t_if_ccip_c0_Rx              c0;
    logic [14:0]                 host_idx;
    logic                        addr_odd, is_8b, idx_ok, req_ok;
    logic                        host_wr_ok, hw_ok, req_err;
    logic [63:0]                 host_lane, host_wdat, sel_reg, rd_dat;
    logic [NUM_REGS-1:0][63:0]   regs;
    logic                        unused_rx;

    assign c0        = cp2af_sRxPort.c0;
    assign host_idx  = c0.hdr.address[15:1];
    assign addr_odd  = c0.hdr.address[0];
    assign is_8b     = (c0.hdr.length == MMIO_LEN_8B);
    assign idx_ok    = (32'(host_idx) < NUM_REGS);
    assign req_ok    = idx_ok && !(is_8b && addr_odd);
    assign host_wr_ok = c0.mmioWrValid && req_ok;
    assign req_err   = (c0.mmioWrValid || c0.mmioRdValid) && !req_ok;
    assign hw_ok     = hw_wr_en && (32'(hw_wr_idx) < NUM_REGS);
    assign unused_rx = ^{c0.hdr.rsvd, cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull};

    // A 4B write replicates its dword so either half can be selected by the lane mask.
    assign host_lane = lane_mask(is_8b, addr_odd);
    assign host_wdat = is_8b ? c0.data : {2{c0.data[31:0]}};

    // Host and AFU masks are disjoint, so same-cycle writes to one register merge cleanly.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [63:0] host_m, hw_m, q;

        assign host_m = (host_wr_ok && host_idx == 15'(i)) ? (WR_MASK[i] & host_lane) : '0;
        assign hw_m   = (hw_ok && hw_wr_idx == IDX_W'(i)) ? ~WR_MASK[i] : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= REG_INIT[i];
            else
                q <= (q & ~(host_m | hw_m)) | (host_wdat & host_m) | (hw_wr_data & hw_m);
        end

        assign regs[i] = q;
    end

    assign csr_q = regs;

    // Read data is taken from the current register state, before this cycle's writes land.
    assign sel_reg = regs[host_idx[IDX_W-1:0]];

    always_comb begin
        rd_dat = '0;
        if (req_ok)
            rd_dat = is_8b ? sel_reg : {32'h0, (addr_odd ? sel_reg[63:32] : sel_reg[31:0])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (req_err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    mmio_csr_bank_if rd_req ();
    mmio_csr_bank_if rd_rsp ();

    assign rd_req.rd_vld = c0.mmioRdValid;
    assign rd_req.rd_tid = c0.hdr.tid;
    assign rd_req.rd_dat = rd_dat;

    mmio_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .rsp   (rd_rsp)
    );

    always_comb begin
        af2cp_sTxPort                = '0;
        af2cp_sTxPort.c2.mmioRdValid = rd_rsp.rd_vld;
        af2cp_sTxPort.c2.hdr.tid     = rd_rsp.rd_tid;
        af2cp_sTxPort.c2.data        = rd_rsp.rd_dat;
    end

endmodule
